// File: rtl/fm_pkg.sv
// Shared constants and FSM encoding for the FM sample scheduler.
// Sample width, idle (carrier-centre) value and scheduler states.
package fm_pkg;
   localparam int FM_DW = 8;
   localparam logic [FM_DW-1:0] FM_IDLE_DATA = 8'h80;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fm_state_t;
endpackage

// File: rtl/fm_sample_fifo.sv
// Synchronous sample FIFO, DEPTH x FM_DW.
// Full/empty come from the occupancy count so wrapped pointers are never ambiguous.
module fm_sample_fifo
   import fm_pkg::*;
#(
   parameter int DEPTH = 16
)(
   input  logic                     clk,
   input  logic                     nRst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [FM_DW-1:0]         wdata,
   output logic [FM_DW-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [FM_DW-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!nRst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/fm_sample_sched.sv
// Paces buffered modulation samples into fm_out at one sample per rate+1 clocks.
// Holds the last sample and raises sticky underflow when a tick finds the FIFO empty.
module fm_sample_sched
   import fm_pkg::*;
#(
   parameter int               DEPTH     = 16,
   parameter int               DIV_W     = 16,
   parameter logic [FM_DW-1:0] IDLE_DATA = FM_IDLE_DATA
)(
   input  logic                   clk,
   input  logic                   nRst,
   input  logic                   wr_valid,
   input  logic [FM_DW-1:0]       wr_data,
   output logic                   wr_ready,
   input  logic                   enable,
   input  logic [DIV_W-1:0]       rate,
   input  logic                   clr_underflow,
   output logic [FM_DW-1:0]       data,
   output logic                   update,
   output logic                   underflow,
   output logic [$clog2(DEPTH):0] level
);
   fm_state_t        state;
   fm_state_t        state_nxt;
   logic [DIV_W-1:0] cnt;
   logic             tick;
   logic             fifo_full;
   logic             fifo_empty;
   logic [FM_DW-1:0] head;

   fm_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .nRst  (nRst),
      .push  (wr_valid),
      .pop   (tick),
      .wdata (wr_data),
      .rdata (head),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign wr_ready = ~fifo_full;

   always_ff @(posedge clk) begin
      if (!nRst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (enable)  state_nxt = ST_RUN;
         ST_RUN:  if (!enable) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      tick = (state == ST_RUN) && enable && (cnt == '0);
   end

   // Divider reloads on entry to RUN and on every tick, so rate changes land at the next reload.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (enable) cnt <= rate;
      end else if (enable) begin
         cnt <= tick ? rate : cnt - DIV_W'(1);
      end
   end

   // Underflow set by an empty tick takes priority over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         data      <= IDLE_DATA;
         update    <= 1'b0;
         underflow <= 1'b0;
      end else begin
         update <= tick & ~fifo_empty;
         if (tick & ~fifo_empty) data <= head;
         if (tick & fifo_empty)  underflow <= 1'b1;
         else if (clr_underflow) underflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fm_sample_sched.sv
// Self-checking bench for fm_sample_sched: directed scenarios plus random traffic,
// all checked against a queue-based behavioural model of the scheduler.
module tb_fm_sample_sched;
   localparam int DEPTH = 16;
   localparam int DIV_W = 16;
   localparam int LW    = 5;

   logic             clk = 1'b0;
   logic             nRst = 1'b0;
   logic             wr_valid = 1'b0;
   logic [7:0]       wr_data = 8'h00;
   logic             wr_ready;
   logic             enable = 1'b0;
   logic [DIV_W-1:0] rate = '0;
   logic             clr_underflow = 1'b0;
   logic [7:0]       data;
   logic             update;
   logic             underflow;
   logic [LW-1:0]    level;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Behavioural model: FIFO as a queue, ticks every (rate+1)th edge after entering run.
   logic [7:0] mq[$];
   logic [7:0] m_data = 8'h80;
   bit         m_upd = 1'b0;
   bit         m_uf = 1'b0;
   bit         m_run = 1'b0;
   int         m_t = 0;

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   fm_sample_sched #(.DEPTH(DEPTH), .DIV_W(DIV_W), .IDLE_DATA(8'h80)) dut (
      .clk           (clk),
      .nRst          (nRst),
      .wr_valid      (wr_valid),
      .wr_data       (wr_data),
      .wr_ready      (wr_ready),
      .enable        (enable),
      .rate          (rate),
      .clr_underflow (clr_underflow),
      .data          (data),
      .update        (update),
      .underflow     (underflow),
      .level         (level)
   );

   function automatic logic [15:0] dut_vec();
      return {data, update, underflow, level, wr_ready};
   endfunction

   function automatic logic [15:0] mdl_vec();
      return {m_data, m_upd, m_uf, LW'(mq.size()), (mq.size() < DEPTH)};
   endfunction

   task automatic step();
      bit tk;
      bit psh;
      @(posedge clk);
      cyc++;
      if (!nRst) begin
         mq.delete();
         m_data = 8'h80; m_upd = 1'b0; m_uf = 1'b0; m_run = 1'b0; m_t = 0;
      end else begin
         tk  = 1'b0;
         psh = wr_valid && (mq.size() < DEPTH);
         if (m_run && !enable) m_run = 1'b0;
         else if (m_run) begin
            m_t++;
            tk = ((m_t % (int'(rate) + 1)) == 0);
         end else if (enable) begin
            m_run = 1'b1; m_t = 0;
         end
         m_upd = 1'b0;
         if (tk && mq.size() > 0) begin
            m_data = mq.pop_front();
            m_upd  = 1'b1;
         end
         if (tk && mq.size() == 0 && !m_upd) m_uf = 1'b1;
         else if (clr_underflow) m_uf = 1'b0;
         if (psh) mq.push_back(wr_data);
      end
      #1;
   endtask

   task automatic test_reset();
      nRst = 1'b0;
      step(); step();
      n_tests++;
      if (dut_vec() !== {8'h80, 1'b0, 1'b0, 5'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: got {data,upd,uf,level,rdy}=%h expected %h", dut_vec(), {8'h80, 1'b0, 1'b0, 5'd0, 1'b1});
      end
      nRst = 1'b1;
   endtask

   task automatic test_pacing();
      logic [7:0] vals [3] = '{8'd20, 8'd40, 8'd60};
      int hit_cyc[$];
      logic [7:0] hit_dat[$];
      int t0;
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_data = vals[i];
         step();
      end
      wr_valid = 1'b0;
      rate = 16'd4; enable = 1'b1; t0 = cyc;
      for (int i = 0; i < 20; i++) begin
         step();
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL pacing_model: cyc %0d got %h expected %h", cyc, dut_vec(), mdl_vec());
         end
         if (update) begin
            hit_cyc.push_back(cyc - t0);
            hit_dat.push_back(data);
         end
      end
      n_tests++;
      if (hit_cyc.size() != 3) begin
         n_fail++;
         $display("FAIL pacing_count: got %0d updates expected 3", hit_cyc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (hit_cyc[i] != 6 + 5 * i || hit_dat[i] !== vals[i]) begin
               n_fail++;
               $display("FAIL pacing_update%0d: got cycle %0d data %0d expected cycle %0d data %0d", i, hit_cyc[i], hit_dat[i], 6 + 5 * i, vals[i]);
            end
         end
      end
      n_tests++;
      if (level !== 5'd0) begin
         n_fail++;
         $display("FAIL pacing_level: got %0d expected 0", level);
      end
   endtask

   task automatic test_underflow();
      int n_upd = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (update) n_upd++;
      end
      n_tests++;
      if (n_upd != 0 || data !== 8'd60 || underflow !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow_hold: got upd=%0d data=%0d uf=%b expected upd=0 data=60 uf=1", n_upd, data, underflow);
      end
      enable = 1'b0; clr_underflow = 1'b1;
      step();
      clr_underflow = 1'b0;
      n_tests++;
      if (underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL underflow_clear: got %b expected 0", underflow);
      end
      rate = 16'd0; enable = 1'b1;
      step();
      clr_underflow = 1'b1;
      step();
      clr_underflow = 1'b0;
      n_tests++;
      if (underflow !== 1'b1 || dut_vec() !== mdl_vec()) begin
         n_fail++;
         $display("FAIL underflow_set_wins: got uf=%b vec=%h expected uf=1 vec=%h", underflow, dut_vec(), mdl_vec());
      end
      enable = 1'b0; clr_underflow = 1'b1;
      step();
      clr_underflow = 1'b0;
   endtask

   task automatic test_full();
      logic [7:0] exp_q[$];
      for (int i = 0; i < 17; i++) begin
         wr_valid = 1'b1; wr_data = 8'($urandom);
         if (i < DEPTH) exp_q.push_back(wr_data);
         step();
         n_tests++;
         if (wr_ready !== (i + 1 < DEPTH) || level !== LW'((i + 1 < DEPTH) ? i + 1 : DEPTH)) begin
            n_fail++;
            $display("FAIL full_push%0d: got rdy=%b level=%0d expected rdy=%b level=%0d", i, wr_ready, level, (i + 1 < DEPTH), (i + 1 < DEPTH) ? i + 1 : DEPTH);
         end
      end
      wr_valid = 1'b0;
      rate = 16'd0; enable = 1'b1;
      step();
      for (int k = 0; k < DEPTH; k++) begin
         step();
         n_tests++;
         if (update !== 1'b1 || data !== exp_q[k]) begin
            n_fail++;
            $display("FAIL full_drain%0d: got upd=%b data=%h expected upd=1 data=%h", k, update, data, exp_q[k]);
         end
      end
      step();
      n_tests++;
      if (dut_vec() !== mdl_vec() || update !== 1'b0) begin
         n_fail++;
         $display("FAIL full_after: got %h expected %h", dut_vec(), mdl_vec());
      end
      enable = 1'b0; clr_underflow = 1'b1;
      step();
      clr_underflow = 1'b0;
   endtask

   task automatic test_sine();
      logic [7:0] tbl [255];
      int idx = 0;
      int got = 0;
      int last = 0;
      bit acc;
      for (int i = 0; i < 255; i++)
         tbl[i] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265 * i / 255.0)));
      rate = 16'd149; enable = 1'b1;
      for (int c = 0; c < 255 * 150 + 500 && got < 255; c++) begin
         wr_valid = (idx < 255);
         wr_data  = tbl[(idx < 255) ? idx : 254];
         acc = wr_valid && wr_ready;
         step();
         if (acc) idx++;
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL sine_model: cyc %0d got %h expected %h", cyc, dut_vec(), mdl_vec());
         end
         if (update) begin
            n_tests++;
            if (data !== tbl[got] || (got > 0 && cyc - last != 150)) begin
               n_fail++;
               $display("FAIL sine_sample%0d: got data=%h gap=%0d expected data=%h gap=150", got, data, cyc - last, tbl[got]);
            end
            last = cyc;
            got++;
         end
      end
      wr_valid = 1'b0;
      n_tests++;
      if (got != 255 || underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL sine_total: got %0d updates uf=%b expected 255 uf=0", got, underflow);
      end
      enable = 1'b0;
      step();
   endtask

   task automatic test_reset_midrun();
      int t0;
      int first = -1;
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_data = 8'($urandom);
         step();
      end
      wr_valid = 1'b0;
      rate = 16'd3; enable = 1'b1;
      step(); step();
      n_tests++;
      if (level !== 5'd5) begin
         n_fail++;
         $display("FAIL midrun_level: got %0d expected 5", level);
      end
      nRst = 1'b0; enable = 1'b0;
      step();
      nRst = 1'b1;
      n_tests++;
      if (level !== 5'd0 || data !== 8'h80 || update !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_reset: got level=%0d data=%h upd=%b expected 0 80 0", level, data, update);
      end
      for (int i = 0; i < 2; i++) begin
         wr_valid = 1'b1; wr_data = 8'($urandom);
         step();
      end
      wr_valid = 1'b0;
      rate = 16'd4; enable = 1'b1; t0 = cyc;
      for (int i = 0; i < 12; i++) begin
         step();
         if (update && first < 0) first = cyc - t0;
      end
      n_tests++;
      if (first != 6) begin
         n_fail++;
         $display("FAIL midrun_restart: got first update at cycle %0d expected 6", first);
      end
      enable = 1'b0;
      step();
   endtask

   task automatic test_random();
      int pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) pct = (c / 500 % 2 == 0) ? 15 : 90;
         if (!enable) rate = DIV_W'($urandom_range(0, 6));
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         wr_valid      = ($urandom_range(0, 99) < pct);
         wr_data       = 8'($urandom);
         clr_underflow = ($urandom_range(0, 15) == 0);
         nRst          = ($urandom_range(0, 999) != 0);
         step();
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL random_model: cyc %0d got %h expected %h", cyc, dut_vec(), mdl_vec());
         end
      end
      nRst = 1'b1; wr_valid = 1'b0; clr_underflow = 1'b0; enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pacing();
      test_underflow();
      test_full();
      test_sine();
      test_reset_midrun();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
